// File: rtl/kmul_pkg.sv
// Shared types and constants for the sequential 16x16 Karatsuba multiplier.
// Holds the FSM state enum, step width, operand widths and per-step operand/shift selection.
package kmul_pkg;

    localparam int unsigned HALF_W = 8;
    localparam int unsigned OPW    = 16;
    localparam int unsigned PRODW  = 32;
    localparam int unsigned STEPW  = 2;
    localparam int unsigned NSTEPS = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    typedef logic [STEPW-1:0] step_t;

    function automatic logic [4:0] step_shift(input step_t s);
        case (s)
            2'd0:       return 5'd0;
            2'd1, 2'd2: return 5'd8;
            default:    return 5'd16;
        endcase
    endfunction

    // Step bit 0 picks the upper x half, step bit 1 the upper y half.
    function automatic logic [HALF_W-1:0] x_half(input step_t s, input logic [OPW-1:0] v);
        return s[0] ? v[OPW-1:HALF_W] : v[HALF_W-1:0];
    endfunction

    function automatic logic [HALF_W-1:0] y_half(input step_t s, input logic [OPW-1:0] v);
        return s[1] ? v[OPW-1:HALF_W] : v[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/karatsuba_mult_8.sv
// Combinational 8x8 unsigned Karatsuba multiplier built from three 4-bit-half products.
module karatsuba_mult_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [3:0] ah, al, bh, bl;
    logic [4:0] as, bs;
    logic [7:0] z0, z2;
    logic [9:0] zm, z1;

    always_comb begin
        ah = a[7:4];
        al = a[3:0];
        bh = b[7:4];
        bl = b[3:0];
        as = {1'b0, ah} + {1'b0, al};
        bs = {1'b0, bh} + {1'b0, bl};
        z0 = {4'b0, al} * {4'b0, bl};
        z2 = {4'b0, ah} * {4'b0, bh};
        zm = {5'b0, as} * {5'b0, bs};
        // Cross term ah*bl + al*bh recovered from the sum product.
        z1 = zm - {2'b0, z0} - {2'b0, z2};
        p  = {z2, z0} + {2'b0, z1, 4'b0};
    end

endmodule

// File: rtl/karatsuba_mult_16_seq.sv
// Sequential 16x16 unsigned multiplier sharing one karatsuba_mult_8 across four partial-product steps.
// Optional KMUL_SEQ_PERF_CNT_EN adds perf_ops/perf_cycles counters.
module karatsuba_mult_16_seq
    import kmul_pkg::*;
#(
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   x,
    input  logic [OPW-1:0]   y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PRODW-1:0] out,
    output logic             busy
`ifdef KMUL_SEQ_PERF_CNT_EN
   ,output logic [PRODW-1:0] perf_ops,
    output logic [PRODW-1:0] perf_cycles
`endif
);

    state_t            state_q, state_d;
    step_t             step_q, step_d;
    logic [OPW-1:0]    xr_q, xr_d, yr_q, yr_d;
    logic [PRODW-1:0]  acc_q, acc_d, out_q, out_d;
    logic [HALF_W-1:0] mul_a, mul_b;
    logic [2*HALF_W-1:0] mul_p;
    logic [PRODW-1:0]  acc_sum;
    logic              has_next;
    step_t             next_step, cand;

    karatsuba_mult_8 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        mul_a   = x_half(step_q, xr_q);
        mul_b   = y_half(step_q, yr_q);
        acc_sum = acc_q + (PRODW'(mul_p) << step_shift(step_q));
    end

    // First later step to execute; with SKIP_ZERO, steps with a zero operand half are passed over.
    always_comb begin
        has_next  = 1'b0;
        next_step = step_q;
        cand      = step_q;
        for (int unsigned i = 1; i < NSTEPS; i++) begin
            cand = step_t'(i);
            if (!has_next && cand > step_q &&
                (SKIP_ZERO == 0 ||
                 (x_half(cand, xr_q) != '0 && y_half(cand, yr_q) != '0))) begin
                has_next  = 1'b1;
                next_step = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xr_d    = x;
                    yr_d    = y;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = acc_sum;
                if (has_next) begin
                    step_d = next_step;
                end else begin
                    out_d   = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out       = out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

`ifdef KMUL_SEQ_PERF_CNT_EN
    logic [PRODW-1:0] ops_q, ops_d, cyc_q, cyc_d;

    always_comb begin
        ops_d = ops_q;
        cyc_d = cyc_q;
        if (out_valid && out_ready) ops_d = ops_q + 1'b1;
        if (busy)                   cyc_d = cyc_q + 1'b1;
        perf_ops    = ops_q;
        perf_cycles = cyc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q <= '0;
            cyc_q <= '0;
        end else begin
            ops_q <= ops_d;
            cyc_q <= cyc_d;
        end
    end
`endif

endmodule

// File: tb/tb_karatsuba_mult_16_seq.sv
// Self-checking bench for karatsuba_mult_16_seq: one instance per SKIP_ZERO setting,
// directed and random operands checked against arithmetic product and latency rules.
module tb_karatsuba_mult_16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[2], ir[2], ov[2], rd[2], bz[2];
    logic [15:0] xv[2], yv[2];
    logic [31:0] outv[2];
`ifdef KMUL_SEQ_PERF_CNT_EN
    logic [31:0] pops[2], pcyc[2];
`endif
    int          total = 0;
    int          bad   = 0;
    int unsigned m_ops[2], m_cyc[2];

    always #5 clk = ~clk;

    karatsuba_mult_16_seq #(.SKIP_ZERO(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .x(xv[0]), .y(yv[0]), .out_valid(ov[0]), .out_ready(rd[0]),
        .out(outv[0]), .busy(bz[0])
`ifdef KMUL_SEQ_PERF_CNT_EN
       ,.perf_ops(pops[0]), .perf_cycles(pcyc[0])
`endif
    );

    karatsuba_mult_16_seq #(.SKIP_ZERO(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .x(xv[1]), .y(yv[1]), .out_valid(ov[1]), .out_ready(rd[1]),
        .out(outv[1]), .busy(bz[1])
`ifdef KMUL_SEQ_PERF_CNT_EN
       ,.perf_ops(pops[1]), .perf_cycles(pcyc[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Edges from accept to out_valid: all four steps, or with skipping, step0 plus
    // every later step whose two operand bytes are both nonzero.
    function automatic int ref_lat(input bit sz, input logic [15:0] a, input logic [15:0] b);
        int n;
        if (!sz) return 4;
        n = 1;
        if (a[15:8] != 8'd0 && b[7:0]  != 8'd0) n++;
        if (a[7:0]  != 8'd0 && b[15:8] != 8'd0) n++;
        if (a[15:8] != 8'd0 && b[15:8] != 8'd0) n++;
        return n;
    endfunction

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input int stall, input string tag);
        int          n, lowcnt, lat;
        logic [31:0] exp_p;
        lat   = ref_lat(d == 1, a, b);
        exp_p = {16'b0, a} * {16'b0, b};
        check({tag, "_ready_before"}, {31'b0, ir[d]}, 32'd1);
        iv[d] = 1'b1;
        xv[d] = a;
        yv[d] = b;
        rd[d] = (stall == 0);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        xv[d] = 16'($urandom);
        yv[d] = 16'($urandom);
        n = 0;
        lowcnt = 0;
        while (!ov[d] && n < 20) begin
            if (!ir[d]) lowcnt++;
            @(posedge clk); #1;
            n++;
        end
        if (!ir[d]) lowcnt++;
        check({tag, "_valid"}, {31'b0, ov[d]}, 32'd1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_product"}, outv[d], exp_p);
        check({tag, "_ready_low"}, lowcnt, lat + 1);
        for (int i = 0; i < stall; i++) begin
            iv[d] = 1'b1;
            xv[d] = 16'($urandom);
            yv[d] = 16'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {31'b0, ov[d]}, 32'd1);
            check({tag, "_hold_out"}, outv[d], exp_p);
            check({tag, "_hold_ready"}, {31'b0, ir[d]}, 32'd0);
        end
        rd[d] = 1'b1;
        if (stall != 0) begin
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        iv[d] = 1'b0;
        check({tag, "_idle_ready"}, {31'b0, ir[d]}, 32'd1);
        check({tag, "_idle_valid"}, {31'b0, ov[d]}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, bz[d]}, 32'd0);
        m_ops[d]++;
        m_cyc[d] += lat + 1 + stall;
    endtask

    initial begin
        logic [15:0] a, b;
        int          st, d;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; rd[i] = 1'b0; xv[i] = '0; yv[i] = '0;
            m_ops[i] = 0; m_cyc[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_ready", {31'b0, ir[i]}, 32'd1);
            check("reset_valid", {31'b0, ov[i]}, 32'd0);
            check("reset_out", outv[i], 32'd0);
            check("reset_busy", {31'b0, bz[i]}, 32'd0);
        end
        rst = 1'b0;

        run_op(0, 16'h1234, 16'h5678, 0, "basic");
        check("basic_const", outv[0], 32'h06260060);
        run_op(0, 16'hFFFF, 16'hFFFF, 0, "max");
        check("max_const", outv[0], 32'hFFFE0001);
        run_op(0, 16'h0000, 16'hFFFF, 0, "zero_b2b");
        run_op(0, 16'h0003, 16'h0005, 10, "backpressure");
        check("backpressure_const", outv[0], 32'h0000000F);

        iv[0] = 1'b1; xv[0] = 16'hABCD; yv[0] = 16'h1111;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        check("midop_busy", {31'b0, bz[0]}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midop_ready", {31'b0, ir[0]}, 32'd1);
        check("midop_valid", {31'b0, ov[0]}, 32'd0);
        check("midop_out", outv[0], 32'd0);
        for (int i = 0; i < 2; i++) begin
            m_ops[i] = 0; m_cyc[i] = 0;
        end

        run_op(0, 16'd2, 16'd3, 0, "after_rst");
        check("after_rst_const", outv[0], 32'd6);
        run_op(0, 16'h00A5, 16'h5A00, 0, "perf2");
        run_op(0, 16'h8001, 16'h7FFE, 0, "perf3");
`ifdef KMUL_SEQ_PERF_CNT_EN
        check("perf_ops_3", pops[0], 32'd3);
        check("perf_cycles_15", pcyc[0], 32'd15);
`endif

        run_op(1, 16'h00FF, 16'h0003, 0, "sz_one");
        check("sz_one_const", outv[1], 32'h000002FD);
        run_op(1, 16'hFF00, 16'h00FF, 0, "sz_two");
        check("sz_two_const", outv[1], 32'h00FE0100);
        run_op(1, 16'h0000, 16'h0000, 0, "sz_zero");
        run_op(1, 16'hFFFF, 16'hFFFF, 2, "sz_full");

        for (int i = 0; i < 30; i++) begin
            d = i % 2;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 2) == 0) a[15:8] = '0;
            if ($urandom_range(0, 2) == 0) a[7:0]  = '0;
            if ($urandom_range(0, 2) == 0) b[15:8] = '0;
            if ($urandom_range(0, 2) == 0) b[7:0]  = '0;
            st = $urandom_range(0, 3);
            run_op(d, a, b, st, "rand");
        end

`ifdef KMUL_SEQ_PERF_CNT_EN
        for (int i = 0; i < 2; i++) begin
            check("perf_ops_model", pops[i], m_ops[i]);
            check("perf_cycles_model", pcyc[i], m_cyc[i]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
